// File: rtl/alu_cmd_if.sv
// Command and result handshake bundle for alu_cmd_queue.
// master = command producer / result consumer, slave = the queue.
interface alu_cmd_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_f;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_r;
    logic [2:0]  out_f;

    modport master (
        output in_valid, in_f, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_r, out_f
    );

    modport slave (
        input  in_valid, in_f, in_a, in_b, out_ready,
        output in_ready, out_valid, out_r, out_f
    );
endinterface

// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding an external combinational ALU, with a registered result stage.
// Optional ALU_CMD_CNT_EN adds a 16-bit completed-result counter (done_cnt).
module alu_cmd_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_cmd_if.slave                 cmd,
    output logic [2:0]               alu_f,
    output logic [31:0]              alu_a,
    output logic [31:0]              alu_b,
    input  logic [31:0]              alu_r,
`ifdef ALU_CMD_CNT_EN
    output logic [15:0]              done_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [2:0]       mem_f [DEPTH];
    logic [31:0]      mem_a [DEPTH];
    logic [31:0]      mem_b [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level_q;
    logic             out_valid_q;
    logic [31:0]      out_r_q;
    logic [2:0]       out_f_q;
    logic             push;
    logic             pop;
    logic             not_empty;

    assign not_empty    = (level_q != '0);
    // in_ready depends only on registered occupancy, never on out_ready
    assign cmd.in_ready = rst_n && (level_q != LVL_W'(DEPTH));
    assign push         = cmd.in_valid && cmd.in_ready;
    assign pop          = not_empty && (!out_valid_q || cmd.out_ready);

    assign alu_f = not_empty ? mem_f[rd_ptr] : 3'd0;
    assign alu_a = not_empty ? mem_a[rd_ptr] : 32'd0;
    assign alu_b = not_empty ? mem_b[rd_ptr] : 32'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_f[wr_ptr] <= cmd.in_f;
            mem_a[wr_ptr] <= cmd.in_a;
            mem_b[wr_ptr] <= cmd.in_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_r_q     <= 32'd0;
            out_f_q     <= 3'd0;
        end else if (pop) begin
            out_valid_q <= 1'b1;
            out_r_q     <= alu_r;
            out_f_q     <= mem_f[rd_ptr];
        end else if (out_valid_q && cmd.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef ALU_CMD_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            done_cnt <= 16'd0;
        else if (out_valid_q && cmd.out_ready)
            done_cnt <= done_cnt + 16'd1;
    end
`endif

    assign cmd.out_valid = out_valid_q;
    assign cmd.out_r     = out_r_q;
    assign cmd.out_f     = out_f_q;
    assign level         = level_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench for alu_cmd_queue: directed scenarios plus randomized traffic
// against a queue-based reference model; ALU stubbed as alu_a ^ alu_b.
module tb_alu_cmd_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  alu_f;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_r;
    logic [2:0]  level;
`ifdef ALU_CMD_CNT_EN
    logic [15:0] done_cnt;
`endif

    alu_cmd_if cmd ();

    alu_cmd_queue #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd      (cmd),
        .alu_f    (alu_f),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_r    (alu_r),
`ifdef ALU_CMD_CNT_EN
        .done_cnt (done_cnt),
`endif
        .level    (level)
    );

    assign alu_r = alu_a ^ alu_b;

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a plain queue of pending commands plus the held result
    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } cmd_t;

    cmd_t        q[$];
    bit          m_ov = 0;
    logic [31:0] m_r = '0;
    logic [2:0]  m_f = '0;
    logic [15:0] m_cnt = '0;
    bit          started = 0;

    always @(posedge clk) begin : model
        bit   do_push, do_pop, hs;
        cmd_t c;
        started = 1;
        if (!rst_n) begin
            q.delete();
            m_ov  = 0;
            m_r   = '0;
            m_f   = '0;
            m_cnt = '0;
        end else begin
            do_push = cmd.in_valid && (q.size() < DEPTH);
            do_pop  = (q.size() > 0) && (!m_ov || cmd.out_ready);
            hs      = m_ov && cmd.out_ready;
            if (hs) m_cnt = m_cnt + 16'd1;
            if (do_pop) begin
                c = q.pop_front();
                m_r  = c.a ^ c.b;
                m_f  = c.f;
                m_ov = 1;
            end else if (hs) begin
                m_ov = 0;
            end
            if (do_push) begin
                c.f = cmd.in_f;
                c.a = cmd.in_a;
                c.b = cmd.in_b;
                q.push_back(c);
            end
        end
    end

    always @(negedge clk) begin : compare
        if (started) begin
            chk("in_ready", {31'd0, cmd.in_ready}, {31'd0, (rst_n && q.size() < DEPTH)});
            chk("out_valid", {31'd0, cmd.out_valid}, {31'd0, m_ov});
            chk("level", {29'd0, level}, 32'(q.size()));
            chk("out_r", cmd.out_r, m_r);
            chk("out_f", {29'd0, cmd.out_f}, {29'd0, m_f});
            chk("alu_a", alu_a, (q.size() > 0) ? q[0].a : 32'd0);
            chk("alu_b", alu_b, (q.size() > 0) ? q[0].b : 32'd0);
            chk("alu_f", {29'd0, alu_f}, (q.size() > 0) ? {29'd0, q[0].f} : 32'd0);
`ifdef ALU_CMD_CNT_EN
            chk("done_cnt", {16'd0, done_cnt}, {16'd0, m_cnt});
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        cmd.in_valid = v;
        cmd.in_f     = f;
        cmd.in_a     = a;
        cmd.in_b     = b;
    endtask

`ifdef ALU_CMD_CNT_EN
    logic [15:0] cnt_before;
`endif

    initial begin
        drive(1'b1, 3'd5, 32'hDEAD_BEEF, 32'h1234_5678);
        cmd.out_ready = 1'b1;
        rst_n = 1'b0;

        // reset held two cycles with in_valid asserted
        tick();
        tick();
        chk("rst_in_ready", {31'd0, cmd.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, cmd.out_valid}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_out_r", cmd.out_r, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
`ifdef ALU_CMD_CNT_EN
        chk("rst_done_cnt", {16'd0, done_cnt}, 32'd0);
`endif

        // single op
        rst_n = 1'b1;
        drive(1'b1, 3'd3, 32'h0000_00F0, 32'h0000_000F);
        tick();
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("single_not_yet", {31'd0, cmd.out_valid}, 32'd0);
        tick();
        chk("single_valid", {31'd0, cmd.out_valid}, 32'd1);
        chk("single_r", cmd.out_r, 32'h0000_00FF);
        chk("single_f", {29'd0, cmd.out_f}, 32'd3);
        chk("single_level", {29'd0, level}, 32'd0);
        tick();
        chk("single_drop", {31'd0, cmd.out_valid}, 32'd0);

        // fill with output stalled
        cmd.out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 3'd0, 32'(i), 32'd0);
            tick();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("fill_level", {29'd0, level}, 32'd4);
        chk("fill_in_ready", {31'd0, cmd.in_ready}, 32'd0);
        chk("fill_out_r", cmd.out_r, 32'd1);
        tick();
        chk("fill_hold", cmd.out_r, 32'd1);

        // drain
`ifdef ALU_CMD_CNT_EN
        cnt_before = done_cnt;
`endif
        cmd.out_ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            tick();
            chk("drain_r", cmd.out_r, 32'(i));
            chk("drain_valid", {31'd0, cmd.out_valid}, 32'd1);
        end
        tick();
        chk("drain_end_valid", {31'd0, cmd.out_valid}, 32'd0);
        chk("drain_end_level", {29'd0, level}, 32'd0);
`ifdef ALU_CMD_CNT_EN
        chk("drain_cnt", {16'd0, done_cnt - cnt_before}, 32'd5);
`endif

        // six more across the pointer wrap, streamed
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 3'(i), 32'(10 + i), 32'd0);
            tick();
            if (i > 1) chk("wrap_order", cmd.out_r, 32'(10 + i - 1));
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        tick();
        chk("wrap_last", cmd.out_r, 32'd16);
        tick();
        chk("wrap_idle", {31'd0, cmd.out_valid}, 32'd0);

        // mid-operation reset
        cmd.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'd7, 32'hA0 + 32'(i), 32'h5);
            tick();
        end
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("mid_level", {29'd0, level}, 32'd3);
        chk("mid_valid", {31'd0, cmd.out_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cmd.out_ready = 1'b1;
        chk("mid_rst_level", {29'd0, level}, 32'd0);
        chk("mid_rst_r", cmd.out_r, 32'd0);
`ifdef ALU_CMD_CNT_EN
        chk("mid_rst_cnt", {16'd0, done_cnt}, 32'd0);
`endif
        tick();
        tick();
        chk("mid_after_valid", {31'd0, cmd.out_valid}, 32'd0);

        // randomized traffic, occasional reset
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 249) != 0);
            drive($urandom_range(0, 3) != 0, 3'($urandom), $urandom, $urandom);
            if (c < 1000)      cmd.out_ready = ($urandom_range(0, 3) == 0);
            else if (c < 2000) cmd.out_ready = ($urandom_range(0, 3) != 0);
            else               cmd.out_ready = $urandom_range(0, 1) != 0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
